img_scanout: RTL and testbench

IMG_SCANOUT -- requirements
Module: img_scanout

---
 rtl/img_scanout.sv | 167 ++++++++++++++++
 tb/tb_img_scanout.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/img_scanout.sv
// img_scanout: reads a frame of bytes from memory and streams them out
// over a valid/ready pixel interface through a 2-entry FIFO.
module img_scanout #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_PIX = 1024,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_dw,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        pix_data,
    output logic [CNT_W-1:0]  pix_index,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    // rd_cnt needs one extra bit to reach NUM_PIX itself
    localparam logic [CNT_W:0]   RD_END   = (CNT_W + 1)'(NUM_PIX);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIX - 1);

    state_t state, state_nx;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [CNT_W:0]    rd_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic              in_flight;

    logic [7:0] fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_cnt;

    logic       start_ok;
    logic       flush;
    logic       issue;
    logic       push;
    logic       pop;
    logic [2:0] lvl;

    logic unused_rdata;

    assign unused_rdata = ^mem_rdata[DATA_W-1:8];

    assign mem_we = 1'b0;
    assign mem_dw = 2'b00;

    assign pix_valid = (fifo_cnt != 2'd0);
    assign pix_data  = fifo_mem[rd_ptr];
    assign pix_index = out_cnt;
    assign pix_last  = pix_valid && (out_cnt == LAST_IDX);

    assign pop  = pix_valid && pix_ready;
    assign push = in_flight;

    // Occupancy after this cycle's pop; counting the pop keeps one
    // pixel per cycle flowing while never exceeding two slots.
    assign lvl = {1'b0, fifo_cnt} + {2'b00, in_flight} - {2'b00, pop};

    assign issue = (state == RUN) && !abort
                && (rd_cnt < RD_END) && (lvl < 3'd2);

    assign mem_addr = issue ? base_q + ADDR_W'(rd_cnt) : mem_addr_q;

    // Next-state logic and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        start_ok = 1'b0;
        flush    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    start_ok = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    flush    = 1'b1;
                    state_nx = IDLE;
                end else if (pop && pix_last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Frame base, counters, read tracking and held address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            rd_cnt     <= '0;
            out_cnt    <= '0;
            in_flight  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mem_addr_q <= mem_addr;
            in_flight  <= issue;
            if (start_ok) begin
                base_q  <= base_addr;
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (issue) rd_cnt <= rd_cnt + 1'b1;
                if (pop)   out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    // Two-entry pixel FIFO; an abort drops contents and any return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
        end else if (flush) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_rdata[7:0];
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_img_scanout.sv
// tb_img_scanout: directed bench for img_scanout with a registered
// byte memory model and per-pixel stream checking.
module tb_img_scanout;

    localparam int NUM_PIX = 1024;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_dw;
    logic [31:0] mem_rdata;
    logic [7:0]  pix_data;
    logic [9:0]  pix_index;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;

    int checks;
    int failures;

    img_scanout dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_dw    (mem_dw),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_index (pix_index),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] img(input logic [31:0] a);
        return a[7:0] ^ (a[15:8] + 8'h5A);
    endfunction

    // Registered-read memory; upper bits carry junk the DUT must ignore
    always_ff @(posedge clk)
        mem_rdata <= {24'hA53C0F, img(mem_addr)};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] b);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 32'hDEAD_0000;
    endtask

    // mode 1: ready high, 2: random ready, 3: 20-cycle stall at 500
    task automatic stream(input logic [31:0] base, input int mode,
                          input int stop_at);
        int cyc, exp_i, stall, acc_cyc, first_v;
        logic [31:0] prev;
        logic fin;
        cyc = 1; exp_i = 0; stall = 0; acc_cyc = 0; first_v = 0;
        prev = base - 32'd1;
        fin = 1'b0;
        while (!fin && cyc < 6000) begin
            if (stop_at >= 0 && pix_valid && exp_i == stop_at) begin
                pix_ready = 1'b0;
                return;
            end
            if (mode == 2)
                pix_ready = 1'($urandom_range(0, 1));
            else if (mode == 3 && pix_valid && exp_i == 500 && stall < 20) begin
                pix_ready = 1'b0;
                stall++;
            end else
                pix_ready = 1'b1;
            #1;
            if (cyc == 1) chk("busy_run", {31'd0, busy}, 32'd1);
            if (mem_addr !== prev) begin
                chk("addr_step", mem_addr, prev + 32'd1);
                prev = mem_addr;
            end
            if (mode == 3 && stall == 20 && exp_i == 500 && !pix_ready)
                chk("stall_addr", mem_addr, base + 32'd501);
            if (pix_valid) begin
                if (first_v == 0) begin
                    first_v = cyc;
                    chk("latency", 32'(cyc), 32'd3);
                end
                chk("pix_data", {24'd0, pix_data}, {24'd0, img(base + 32'(exp_i))});
                chk("pix_index", {22'd0, pix_index}, 32'(exp_i));
                chk("pix_last", {31'd0, pix_last},
                    {31'd0, exp_i == NUM_PIX - 1});
                if (pix_ready) begin
                    exp_i++;
                    acc_cyc = cyc;
                end
            end
            if (done) begin
                chk("done_count", 32'(exp_i), 32'(NUM_PIX));
                chk("done_time", 32'(cyc), 32'(acc_cyc + 1));
                if (mode == 1) chk("frame_len", 32'(cyc), 32'd1027);
                @(negedge clk);
                chk("done_pulse", {31'd0, done}, 32'd0);
                chk("idle_busy", {31'd0, busy}, 32'd0);
                fin = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_done"},  {31'd0, done},      32'd0);
        chk({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({tag, "_last"},  {31'd0, pix_last},  32'd0);
        chk({tag, "_data"},  {24'd0, pix_data},  32'd0);
        chk({tag, "_index"}, {22'd0, pix_index}, 32'd0);
        chk({tag, "_addr"},  mem_addr,           32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        pix_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        chk("mem_we", {31'd0, mem_we}, 32'd0);
        chk("mem_dw", {30'd0, mem_dw}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_wait", {31'd0, busy}, 32'd0);

        // full frame, ready always high
        do_start(32'h2000);
        stream(32'h2000, 1, -1);

        // random backpressure
        do_start(32'h2000);
        stream(32'h2000, 2, -1);

        // long stall at pixel 500
        do_start(32'h2000);
        stream(32'h2000, 3, -1);

        // abort at pixel 300, with a competing start
        do_start(32'h2000);
        stream(32'h2000, 1, 300);
        abort     = 1'b1;
        start     = 1'b1;
        base_addr = 32'h4000;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy",  {31'd0, busy},      32'd0);
        chk("abort_valid", {31'd0, pix_valid}, 32'd0);
        chk("abort_done",  {31'd0, done},      32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet_v", {31'd0, pix_valid}, 32'd0);
            chk("abort_quiet_d", {31'd0, done},      32'd0);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_prio", {31'd0, busy}, 32'd0);
        do_start(32'h3100);
        stream(32'h3100, 1, -1);

        // reset mid-frame at pixel 700
        do_start(32'h2000);
        stream(32'h2000, 2, 700);
        start     = 1'b1;
        base_addr = 32'h5000;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_start_busy", {31'd0, busy}, 32'd1);
        chk("busy_start_idx", {22'd0, pix_index}, 32'd700);
        chk("busy_start_data", {24'd0, pix_data}, {24'd0, img(32'h2000 + 32'd700)});
        #1 rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        do_start(32'h2000);
        stream(32'h2000, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
